// File: rtl/neureka_evt_collector_if.sv
// -----------------------------------------------------------------------------
// neureka_evt_collector_if
//   Bundles the accelerator-facing event/busy inputs, the coalescing controls
//   and the interrupt/perf outputs of the event collector.
//
//   Signals (directions as seen by the collector, modport slave):
//     clear_i            in   synchronous clear of all collector state
//     evt_i              in   raw one-cycle event pulses [core][event]
//     busy_i             in   accelerator busy flag
//     coal_thr_i         in   coalescing threshold (0/1 = no coalescing)
//     timeout_i          in   coalescing timeout in cycles (0 = disabled)
//     evt_o              out  coalesced one-cycle event pulses [core][event]
//     busy_cycles_o      out  cumulative busy cycles, saturating
//     job_cnt_o          out  completed jobs, wrapping
//     last_job_cycles_o  out  duration of the last completed job, saturating
//     overflow_o         out  sticky pending-counter saturation flag
//
//   modport master: the side driving the accelerator events (top-level / bench)
//   modport slave : the collector itself
// -----------------------------------------------------------------------------
interface neureka_evt_collector_if #(
    parameter int unsigned N_CORES       = 8,
    parameter int unsigned REGFILE_N_EVT = 2,
    parameter int unsigned EVT_CNT_W     = 4,
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned TO_W          = 16
);
    logic                                      clear_i;
    logic [N_CORES-1:0][REGFILE_N_EVT-1:0]     evt_i;
    logic                                      busy_i;
    logic [EVT_CNT_W-1:0]                      coal_thr_i;
    logic [TO_W-1:0]                           timeout_i;
    logic [N_CORES-1:0][REGFILE_N_EVT-1:0]     evt_o;
    logic [CNT_W-1:0]                          busy_cycles_o;
    logic [CNT_W-1:0]                          job_cnt_o;
    logic [CNT_W-1:0]                          last_job_cycles_o;
    logic                                      overflow_o;

    modport master (
        output clear_i, evt_i, busy_i, coal_thr_i, timeout_i,
        input  evt_o, busy_cycles_o, job_cnt_o, last_job_cycles_o, overflow_o
    );

    modport slave (
        input  clear_i, evt_i, busy_i, coal_thr_i, timeout_i,
        output evt_o, busy_cycles_o, job_cnt_o, last_job_cycles_o, overflow_o
    );
endinterface

// File: rtl/neureka_evt_collector.sv
// -----------------------------------------------------------------------------
// neureka_evt_collector
//   Coalesces raw per-core completion events from the accelerator into
//   per-core interrupt pulses (programmable count threshold plus an
//   end-of-job flush) and keeps job-level performance counters.
//
//   Ports:
//     clk_i    in  clock
//     rst_ni   in  synchronous active-low reset
//     evt_bus  neureka_evt_collector_if.slave (events, busy, controls, outputs)
//
//   Optional feature macro: NEUREKA_EVT_TIMEOUT_EN
//     defined   : a global timer forces a flush after timeout_i cycles of
//                 pending events (timeout_i = 0 disables it)
//     undefined : timeout_i is ignored; flush only from the FSM FLUSH state
// -----------------------------------------------------------------------------
module neureka_evt_collector #(
    parameter int unsigned N_CORES       = 8,
    parameter int unsigned REGFILE_N_EVT = 2,
    parameter int unsigned EVT_CNT_W     = 4,
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned TO_W          = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    neureka_evt_collector_if.slave    evt_bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FLUSH = 2'd2
    } state_e;

    localparam logic [EVT_CNT_W-1:0] PEND_MAX = '1;

    state_e                                r_state;
    state_e                                w_state_nxt;
    logic                                  w_clr;
    logic                                  w_fsm_flush;
    logic                                  w_job_start;
    logic                                  w_in_busy;
    logic                                  w_job_end;
    logic                                  w_flush;
    logic [EVT_CNT_W-1:0]                  w_thr;
    logic [N_CORES-1:0][REGFILE_N_EVT-1:0] w_fire;

    logic [EVT_CNT_W-1:0]                  r_pend [N_CORES][REGFILE_N_EVT];
    logic [N_CORES-1:0][REGFILE_N_EVT-1:0] r_evt_o;
    logic                                  r_overflow;
    logic [CNT_W-1:0]                      r_cur_cycles;
    logic [CNT_W-1:0]                      r_busy_cycles;
    logic [CNT_W-1:0]                      r_job_cnt;
    logic [CNT_W-1:0]                      r_last_job;

    // Reset and clear are indistinguishable for every register.
    assign w_clr = !rst_ni || evt_bus.clear_i;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk_i) begin
        if (w_clr) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (evt_bus.busy_i)  w_state_nxt = BUSY;
            BUSY:    if (!evt_bus.busy_i) w_state_nxt = FLUSH;
            FLUSH:   w_state_nxt = evt_bus.busy_i ? BUSY : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_fsm_flush = (r_state == FLUSH);
        w_job_start = ((r_state == IDLE) || (r_state == FLUSH)) && evt_bus.busy_i;
        w_in_busy   = (r_state == BUSY) && evt_bus.busy_i;
        w_job_end   = (r_state == BUSY) && !evt_bus.busy_i;
    end

    // -------------------------------------------------------- perf counters
    always_ff @(posedge clk_i) begin
        if (w_clr) begin
            r_cur_cycles  <= '0;
            r_busy_cycles <= '0;
            r_job_cnt     <= '0;
            r_last_job    <= '0;
        end else begin
            if (w_job_start) begin
                r_cur_cycles  <= CNT_W'(1);
                r_busy_cycles <= sat_inc(r_busy_cycles);
            end else if (w_in_busy) begin
                r_cur_cycles  <= sat_inc(r_cur_cycles);
                r_busy_cycles <= sat_inc(r_busy_cycles);
            end
            if (w_job_end) begin
                r_job_cnt  <= r_job_cnt + CNT_W'(1);
                r_last_job <= r_cur_cycles;
            end
        end
    end

    // ------------------------------------------------------- flush sources
`ifdef NEUREKA_EVT_TIMEOUT_EN
    logic [TO_W-1:0] r_timer;
    logic            w_any_pend;
    logic            w_to_flush;

    always_comb begin
        w_any_pend = 1'b0;
        for (int unsigned c = 0; c < N_CORES; c++) begin
            for (int unsigned e = 0; e < REGFILE_N_EVT; e++) begin
                w_any_pend = w_any_pend | (r_pend[c][e] != '0);
            end
        end
    end

    assign w_to_flush = w_any_pend && (evt_bus.timeout_i != '0) &&
                        (r_timer == evt_bus.timeout_i);

    always_ff @(posedge clk_i) begin
        if (w_clr || !w_any_pend || (evt_bus.timeout_i == '0) || w_to_flush)
            r_timer <= '0;
        else
            r_timer <= r_timer + TO_W'(1);
    end

    assign w_flush = w_fsm_flush | w_to_flush;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^evt_bus.timeout_i;
    assign w_flush          = w_fsm_flush;
`endif

    // ------------------------------------------------- coalescing counters
    assign w_thr = (evt_bus.coal_thr_i == '0) ? EVT_CNT_W'(1) : evt_bus.coal_thr_i;

    always_comb begin
        w_fire = '0;
        for (int unsigned c = 0; c < N_CORES; c++) begin
            for (int unsigned e = 0; e < REGFILE_N_EVT; e++) begin
                w_fire[c][e] = (r_pend[c][e] != '0) &&
                               ((r_pend[c][e] >= w_thr) || w_flush);
            end
        end
    end

    // A counter at max always fires (thr can never exceed max), so a new
    // event landing on a saturated counter is flagged even though it is
    // kept as the fresh pending count of 1.
    always_ff @(posedge clk_i) begin
        if (w_clr) begin
            r_evt_o    <= '0;
            r_overflow <= 1'b0;
            for (int unsigned c = 0; c < N_CORES; c++) begin
                for (int unsigned e = 0; e < REGFILE_N_EVT; e++) begin
                    r_pend[c][e] <= '0;
                end
            end
        end else begin
            r_evt_o <= w_fire;
            for (int unsigned c = 0; c < N_CORES; c++) begin
                for (int unsigned e = 0; e < REGFILE_N_EVT; e++) begin
                    if (w_fire[c][e])
                        r_pend[c][e] <= evt_bus.evt_i[c][e] ? EVT_CNT_W'(1) : '0;
                    else if (evt_bus.evt_i[c][e] && (r_pend[c][e] != PEND_MAX))
                        r_pend[c][e] <= r_pend[c][e] + EVT_CNT_W'(1);
                    if (evt_bus.evt_i[c][e] && (r_pend[c][e] == PEND_MAX))
                        r_overflow <= 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------- outputs
    assign evt_bus.evt_o             = r_evt_o;
    assign evt_bus.busy_cycles_o     = r_busy_cycles;
    assign evt_bus.job_cnt_o         = r_job_cnt;
    assign evt_bus.last_job_cycles_o = r_last_job;
    assign evt_bus.overflow_o        = r_overflow;

endmodule

// File: tb/tb_neureka_evt_collector.sv
// -----------------------------------------------------------------------------
// tb_neureka_evt_collector
//   Self-checking bench for neureka_evt_collector. Expected output pulses are
//   queued with their cycle number when stimulus is driven and compared when
//   evt_o goes non-zero; perf counters and flags are checked directly.
//   Honours NEUREKA_EVT_TIMEOUT_EN for the timeout scenario.
// -----------------------------------------------------------------------------
module tb_neureka_evt_collector;

    localparam int unsigned N_CORES       = 8;
    localparam int unsigned REGFILE_N_EVT = 2;
    localparam int unsigned EVT_CNT_W     = 4;
    localparam int unsigned CNT_W         = 32;
    localparam int unsigned TO_W          = 16;

    typedef logic [N_CORES-1:0][REGFILE_N_EVT-1:0] evt_vec_t;
    typedef struct {
        int unsigned cyc;
        evt_vec_t    vec;
    } exp_t;

    logic        clk_i  = 1'b0;
    logic        rst_ni = 1'b0;
    int unsigned cyc    = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        sb_q[$];

    neureka_evt_collector_if #(
        .N_CORES       (N_CORES),
        .REGFILE_N_EVT (REGFILE_N_EVT),
        .EVT_CNT_W     (EVT_CNT_W),
        .CNT_W         (CNT_W),
        .TO_W          (TO_W)
    ) evt_bus ();

    neureka_evt_collector #(
        .N_CORES       (N_CORES),
        .REGFILE_N_EVT (REGFILE_N_EVT),
        .EVT_CNT_W     (EVT_CNT_W),
        .CNT_W         (CNT_W),
        .TO_W          (TO_W)
    ) u_dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .evt_bus (evt_bus)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(negedge clk_i);
    endtask

    function automatic evt_vec_t onehot(input int unsigned c, input int unsigned e);
        evt_vec_t v;
        v = '0;
        v[c][e] = 1'b1;
        return v;
    endfunction

    task automatic push_exp(input int unsigned at, input evt_vec_t v);
        exp_t x;
        x.cyc = at;
        x.vec = v;
        sb_q.push_back(x);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_evt_o"},       64'(evt_bus.evt_o), 64'd0);
        check_eq({tag, "_busy_cycles"}, 64'(evt_bus.busy_cycles_o), 64'd0);
        check_eq({tag, "_job_cnt"},     64'(evt_bus.job_cnt_o), 64'd0);
        check_eq({tag, "_last_job"},    64'(evt_bus.last_job_cycles_o), 64'd0);
        check_eq({tag, "_overflow"},    64'(evt_bus.overflow_o), 64'd0);
    endtask

    // Scoreboard monitor: flags overdue expectations and compares each pulse.
    always @(negedge clk_i) begin
        exp_t x;
        while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            x = sb_q.pop_front();
            check_eq("evt_missing", 64'(cyc), 64'(x.cyc));
        end
        if (evt_bus.evt_o != '0) begin
            if (sb_q.size() == 0) begin
                check_eq("evt_unexpected", 64'(evt_bus.evt_o), 64'd0);
            end else begin
                x = sb_q.pop_front();
                check_eq("evt_cycle", 64'(cyc), 64'(x.cyc));
                check_eq("evt_vec", 64'(evt_bus.evt_o), 64'(x.vec));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned d;
        evt_bus.clear_i    = 1'b0;
        evt_bus.evt_i      = '0;
        evt_bus.busy_i     = 1'b0;
        evt_bus.coal_thr_i = '0;
        evt_bus.timeout_i  = '0;

        // Reset state
        step(4);
        check_zero_outputs("reset");
        rst_ni = 1'b1;
        step(2);

        // 1: no coalescing, two-cycle latency, single-bit pulse
        evt_bus.coal_thr_i = '0;
        d = cyc;
        push_exp(d + 2, onehot(2, 1));
        evt_bus.evt_i[2][1] = 1'b1;
        step(1);
        evt_bus.evt_i = '0;
        step(4);

        // 2: threshold 3 during a job; one coalesced pulse, nothing on flush
        evt_bus.coal_thr_i = 4'd3;
        evt_bus.busy_i     = 1'b1;
        step(3);
        d = cyc;
        push_exp(d + 6, onehot(0, 0));
        for (int i = 0; i < 10; i++) begin
            evt_bus.evt_i = '0;
            if (i == 0 || i == 3 || i == 4) evt_bus.evt_i[0][0] = 1'b1;
            step(1);
        end
        evt_bus.busy_i = 1'b0;
        step(5);
        check_eq("t2_job_cnt",     64'(evt_bus.job_cnt_o), 64'd1);
        check_eq("t2_busy_cycles", 64'(evt_bus.busy_cycles_o), 64'd13);
        check_eq("t2_last_job",    64'(evt_bus.last_job_cycles_o), 64'd13);

        // 3: clear, then a 50-cycle job with sub-threshold events flushed at end
        evt_bus.clear_i    = 1'b1;
        evt_bus.coal_thr_i = 4'd4;
        step(1);
        evt_bus.clear_i = 1'b0;
        check_eq("t3_job_after_clear",  64'(evt_bus.job_cnt_o), 64'd0);
        check_eq("t3_busy_after_clear", 64'(evt_bus.busy_cycles_o), 64'd0);
        d = cyc;
        push_exp(d + 52, onehot(1, 0));
        evt_bus.busy_i = 1'b1;
        for (int i = 0; i < 50; i++) begin
            evt_bus.evt_i = '0;
            if (i == 5 || i == 10) evt_bus.evt_i[1][0] = 1'b1;
            step(1);
        end
        evt_bus.evt_i  = '0;
        evt_bus.busy_i = 1'b0;
        step(5);
        check_eq("t3_job_cnt",     64'(evt_bus.job_cnt_o), 64'd1);
        check_eq("t3_last_job",    64'(evt_bus.last_job_cycles_o), 64'd50);
        check_eq("t3_busy_cycles", 64'(evt_bus.busy_cycles_o), 64'd50);

        // 4: event on the firing cycle is kept as pend=1
        evt_bus.coal_thr_i = 4'd2;
        d = cyc;
        push_exp(d + 3, onehot(3, 0));
        push_exp(d + 7, onehot(3, 0));
        for (int i = 0; i < 10; i++) begin
            evt_bus.evt_i = '0;
            if (i == 0 || i == 1 || i == 2 || i == 5) evt_bus.evt_i[3][0] = 1'b1;
            step(1);
        end
        evt_bus.evt_i = '0;
        step(3);

        // 5: saturation sets sticky overflow; clear zeroes everything
        evt_bus.coal_thr_i = 4'd15;
        d = cyc;
        push_exp(d + 16, onehot(0, 1));
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check_eq("t5_overflow_before", 64'(evt_bus.overflow_o), 64'd0);
            evt_bus.evt_i = '0;
            evt_bus.evt_i[0][1] = 1'b1;
            step(1);
        end
        evt_bus.evt_i = '0;
        step(1);
        check_eq("t5_overflow_set", 64'(evt_bus.overflow_o), 64'd1);
        step(5);
        check_eq("t5_overflow_sticky", 64'(evt_bus.overflow_o), 64'd1);
        // clear wins over a coincident event
        evt_bus.clear_i     = 1'b1;
        evt_bus.evt_i[5][0] = 1'b1;
        step(1);
        evt_bus.clear_i = 1'b0;
        evt_bus.evt_i   = '0;
        check_zero_outputs("t5_clear");
        // with pend truly cleared, one event each stays below threshold 2
        evt_bus.coal_thr_i  = 4'd2;
        evt_bus.evt_i[5][0] = 1'b1;
        evt_bus.evt_i[0][1] = 1'b1;
        step(1);
        evt_bus.evt_i = '0;
        step(4);
        d = cyc;
        push_exp(d + 2, onehot(5, 0) | onehot(0, 1));
        evt_bus.evt_i[5][0] = 1'b1;
        evt_bus.evt_i[0][1] = 1'b1;
        step(1);
        evt_bus.evt_i = '0;
        step(4);

        // 6: single event below threshold during a long job
        evt_bus.coal_thr_i = 4'd8;
        evt_bus.timeout_i  = 16'd20;
        evt_bus.busy_i     = 1'b1;
        step(3);
        d = cyc;
`ifdef NEUREKA_EVT_TIMEOUT_EN
        push_exp(d + 22, onehot(4, 0));
`else
        push_exp(d + 42, onehot(4, 0));
`endif
        evt_bus.evt_i[4][0] = 1'b1;
        step(1);
        evt_bus.evt_i = '0;
        step(39);
        evt_bus.busy_i = 1'b0;
        step(6);
        check_eq("t6_job_cnt", 64'(evt_bus.job_cnt_o), 64'd1);

        check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
